// File: rtl/seq_det_moore_param_if.sv
// Serial-input bundle for the Moore pattern detector.
// match_cnt exists only when SEQ_DET_MATCH_CNT_EN is defined.
interface seq_det_moore_param_if #(
   parameter int CNT_W = 8
);
   logic in_valid;
   logic in;
   logic overlap;
   logic out;
`ifdef SEQ_DET_MATCH_CNT_EN
   logic [CNT_W-1:0] match_cnt;

   modport master (
      output in_valid,
      output in,
      output overlap,
      input  out,
      input  match_cnt
   );

   modport slave (
      input  in_valid,
      input  in,
      input  overlap,
      output out,
      output match_cnt
   );
`else
   modport master (
      output in_valid,
      output in,
      output overlap,
      input  out
   );

   modport slave (
      input  in_valid,
      input  in,
      input  overlap,
      output out
   );
`endif

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("seq_det_moore_param_if: CNT_W must be at least 1");
   end
endinterface

// File: rtl/seq_det_moore_param.sv
// Parametrised Moore serial-pattern detector with KMP fallback resolved at elaboration.
// Optional saturating match counter compiled in with SEQ_DET_MATCH_CNT_EN.
module seq_det_moore_param #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
   parameter int               CNT_W   = 8
) (
   input logic                  clk,
   input logic                  reset,
   seq_det_moore_param_if.slave bus
);
   localparam int SW  = $clog2(PAT_W + 1);
   localparam int NST = 2 ** SW;
   localparam logic [15:0] P16 = 16'(PATTERN);

   if (PAT_W < 2 || PAT_W > 16 || CNT_W < 1) begin : g_bad_param
      $error("seq_det_moore_param: PAT_W must be 2..16 and CNT_W at least 1");
   end

   // Longest suffix of (first k pattern bits, b) that is also a pattern prefix.
   function automatic int step(input int k, input logic b);
      logic [16:0] s;
      logic        ok;
      int          best;
      s    = 17'd0;
      s[0] = b;
      for (int j = 1; j <= 16; j++) begin
         if (j <= k) begin
            s[5'(j)] = P16[4'(PAT_W - k + j - 1)];
         end
      end
      best = 0;
      for (int l = 1; l <= 16; l++) begin
         if (l <= k + 1 && l <= PAT_W) begin
            ok = 1'b1;
            for (int j = 0; j < 16; j++) begin
               if (j < l && s[5'(j)] != P16[4'(PAT_W - l + j)]) begin
                  ok = 1'b0;
               end
            end
            if (ok) begin
               best = l;
            end
         end
      end
      return best;
   endfunction

   // Longest proper suffix of the whole pattern that is also a prefix.
   function automatic int fail_len();
      logic ok;
      int   best;
      best = 0;
      for (int l = 1; l < 16; l++) begin
         if (l < PAT_W) begin
            ok = 1'b1;
            for (int j = 0; j < 16; j++) begin
               if (j < l && P16[4'(j)] != P16[4'(PAT_W - l + j)]) begin
                  ok = 1'b0;
               end
            end
            if (ok) begin
               best = l;
            end
         end
      end
      return best;
   endfunction

   localparam int FB = fail_len();
   localparam logic [SW-1:0] ST_IDLE  = SW'(0);
   localparam logic [SW-1:0] ST_MATCH = SW'(PAT_W);

   logic [SW-1:0] w_nxt0 [0:NST-1];
   logic [SW-1:0] w_nxt1 [0:NST-1];
   logic [SW-1:0] w_ovl0;
   logic [SW-1:0] w_ovl1;
   logic [SW-1:0] w_next;
   logic [SW-1:0] r_state;
   logic          r_out;

   // Only partial-match states get real entries; the rest are never indexed live.
   for (genvar k = 0; k < NST; k++) begin : g_tbl
      if (k < PAT_W) begin : g_live
         localparam int N0 = step(k, 1'b0);
         localparam int N1 = step(k, 1'b1);
         assign w_nxt0[k] = SW'(N0);
         assign w_nxt1[k] = SW'(N1);
      end else begin : g_dead
         assign w_nxt0[k] = ST_IDLE;
         assign w_nxt1[k] = ST_IDLE;
      end
   end

   localparam int OV0 = step(FB, 1'b0);
   localparam int OV1 = step(FB, 1'b1);
   assign w_ovl0 = SW'(OV0);
   assign w_ovl1 = SW'(OV1);

   // Next-state selection; leaving the match state restarts from 0 or from the overlap border.
   always_comb begin
      w_next = r_state;
      if (r_state > ST_MATCH) begin
         w_next = ST_IDLE;
      end else if (!bus.in_valid) begin
         w_next = r_state;
      end else if (r_state == ST_MATCH) begin
         if (bus.overlap) begin
            w_next = bus.in ? w_ovl1 : w_ovl0;
         end else begin
            w_next = bus.in ? w_nxt1[0] : w_nxt0[0];
         end
      end else begin
         w_next = bus.in ? w_nxt1[r_state] : w_nxt0[r_state];
      end
   end

   // State register with the match flag registered alongside it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_out   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_out   <= (w_next == ST_MATCH);
      end
   end

   assign bus.out = r_out;

`ifdef SEQ_DET_MATCH_CNT_EN
   logic [CNT_W-1:0] r_cnt;

   // Count each valid bit that lands in the match state; holding there does not count.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (bus.in_valid && (r_state <= ST_MATCH) && (w_next == ST_MATCH)
                   && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign bus.match_cnt = r_cnt;
`endif
endmodule

// File: doc/seq_det_moore_param.md
# seq_det_moore_param

Parametrised Moore serial-pattern detector, the successor to the fixed 4-bit non-overlapping detector. It compares a serial bitstream, gated by a valid strobe, against a `PAT_W`-bit `PATTERN`. A runtime input selects overlapping or non-overlapping detection. Matches are reported as a Moore output decoded from the state register, with an optional saturating match counter. It sits on the serial input path, feeding frame/sync-detect logic downstream.

## Interface
- `PAT_W`, default 4: pattern length in bits; legal range 2..16.
- `PATTERN`, default 4'b1010: target sequence; `PATTERN[PAT_W-1]` is the first bit expected on the wire.
- `CNT_W`, default 8: width of `match_cnt`; only used when the counter is compiled in.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `reset` input, 1: synchronous, active-high reset; sampled on the `clk` rising edge.
- `in_valid` input, 1: `in` carries a sequence bit this cycle.
- `in` input, 1: serial data bit.
- `overlap` input, 1: 1 = overlapping detection, 0 = non-overlapping; sampled on valid cycles.
- `out` output, 1: Moore match flag; high exactly while the FSM is in the match state.
- `match_cnt` output, `CNT_W`: saturating count of match-state entries (present only with `SEQ_DET_MATCH_CNT_EN`).

## Operation
- State register `state` has width `$clog2(PAT_W+1)`.
- State k (0..`PAT_W-1`) means the last k valid bits equal `PATTERN[PAT_W-1 -: k]`. State `PAT_W` is the match state.
- Transition, only when `in_valid`=1, from state k < `PAT_W`:
  - If `in` == `PATTERN[PAT_W-1-k]`, go to k+1.
  - Otherwise go to the fallback state: the longest proper suffix of (matched prefix, `in`) that is also a prefix of `PATTERN`. This is KMP failure logic, resolved at elaboration from `PATTERN`; no runtime pattern storage.
- Transition from the match state:
  - `overlap`=0: behave as state 0 with the current bit. Example for 1010: `in`=1 goes to 1, `in`=0 goes to 0.
  - `overlap`=1: behave as state f with the current bit, where f is the longest proper suffix of `PATTERN` that is also a prefix. For 1010, f=2.
- `in_valid`=0: state holds, including the match state, so `out` stays high until the next valid bit.
- `out` = (`state` == `PAT_W`), pure decode of the state register with no input term.
- Unreachable encodings (> `PAT_W`) go to state 0 on the next edge regardless of `in_valid`.
- `overlap` may change any cycle. It affects only the transition leaving the match state on that cycle.
- Reset values: `state`=0, `out`=0, `match_cnt`=0.
- Reset has priority over `in_valid` and `overlap`. A partial match in progress is discarded.

## Timing
- Latency: `out` rises in the cycle after the edge that samples the final pattern bit with `in_valid`=1.
- With back-to-back valid bits, `out` stays high for exactly 1 cycle.
- Back-to-back overlapping matches can produce `out` pulses as close as every (`PAT_W`−f) valid bits.
- One new bit is accepted per clock. There is no backpressure and no ready signal.
- The counter increments on the same edge that enters the match state, so `match_cnt` updates in the same cycle `out` rises. A held match state does not re-count.

## Configuration
- Macro: `SEQ_DET_MATCH_CNT_EN`.
- Defined:
  - `match_cnt` port and counter are present.
  - The counter increments once per match-state entry and saturates at 2^`CNT_W`−1.
  - It clears only on `reset`.
- Undefined: the `match_cnt` port and the counter logic are absent; all other behaviour is identical.

## Test plan
Default parameters unless noted.
- **Non-overlapping back-to-back:** `overlap`=0, valid every cycle, bits 1,0,1,0,1,0,1,0 -> `out` high for one cycle after bit 4 and after bit 8; `match_cnt`=2.
- **Overlap mode:** bits 1,0,1,0,1,0.
  - `overlap`=0 -> one pulse, after bit 4.
  - `overlap`=1 -> two pulses, after bits 4 and 6; `match_cnt`=2.
- **False start / fallback:** bits 1,1,0,1,0 -> state goes 1,1,2,3,4; single `out` pulse after bit 5.
- **Valid gaps:** bits 1,0,1,0 with `in_valid`=0 for 2 cycles between each bit, then 3 idle cycles after bit 4 -> state holds across gaps; `out` rises after bit 4 and stays high through the 3 idle cycles; `match_cnt`=1.
- **Reset mid-pattern:** bits 1,0,1, then `reset`=1 for 1 cycle, then bit 0 -> no match, state 0. Then bits 1,0,1,0 -> match, `match_cnt`=1.
- **Saturation:** `CNT_W`=2, 5 non-overlapping matches -> `match_cnt` reads 1,2,3,3,3.
